fifo_status_monitor: RTL and testbench

FIFO_STATUS_MONITOR -- requirements
Module: fifo_status_monitor

---
 rtl/fifo_status_monitor.sv | 120 ++++++++++++
 tb/tb_fifo_status_monitor.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_status_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fifo_status_monitor                                        |
// | Description : Tracks the occupancy of five FIFOs (main, VC0, VC1, D0,    |
// |               D1) from their push/pop strobes. It reports empty, full,   |
// |               almost-empty and almost-full status for each FIFO, keeps a |
// |               sticky overflow/underflow error bit per FIFO, and raises a |
// |               one-cycle pulse when any error bit first sets.             |
// | Ports       : clk, reset          - clock, sync active-high reset        |
// |               push, pop [4:0]     - per-FIFO strobes (bit0 main, bit1    |
// |                                     VC0, bit2 VC1, bit3 D0, bit4 D1)     |
// |               *_low, *_high [4:0] - per-FIFO almost-empty/full levels    |
// |               empties, fulls      - count == 0 / count == FIFO_DEPTH     |
// |               almost_empty/full   - count <= low / count >= high         |
// |               errors              - sticky over/underflow per FIFO       |
// |               err_pulse           - one cycle as an errors bit first sets|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fifo_status_monitor #(
   parameter int FIFO_DEPTH = 16            // legal range 1..31
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] push,
   input  logic [4:0] pop,
   input  logic [4:0] main_fifo_low,
   input  logic [4:0] main_fifo_high,
   input  logic [4:0] Vco_low,
   input  logic [4:0] Vco_high,
   input  logic [4:0] Vc1_low,
   input  logic [4:0] Vc1_high,
   input  logic [4:0] Do_low,
   input  logic [4:0] Do_high,
   input  logic [4:0] D1_low,
   input  logic [4:0] D1_high,
   output logic [4:0] empties,
   output logic [4:0] fulls,
   output logic [4:0] almost_empty,
   output logic [4:0] almost_full,
   output logic [4:0] errors,
   output logic       err_pulse
);

   localparam logic [4:0] DEPTH = 5'(FIFO_DEPTH);
   localparam int         NUM_FIFOS = 5;

   // Thresholds gathered into arrays so every FIFO uses the same slice logic.
   logic [4:0] low_th  [NUM_FIFOS];
   logic [4:0] high_th [NUM_FIFOS];

   assign low_th[0]  = main_fifo_low;
   assign high_th[0] = main_fifo_high;
   assign low_th[1]  = Vco_low;
   assign high_th[1] = Vco_high;
   assign low_th[2]  = Vc1_low;
   assign high_th[2] = Vc1_high;
   assign low_th[3]  = Do_low;
   assign high_th[3] = Do_high;
   assign low_th[4]  = D1_low;
   assign high_th[4] = D1_high;

   logic [4:0] count      [NUM_FIFOS];
   logic [4:0] count_next [NUM_FIFOS];
   logic [4:0] err_event;

   generate
      for (genvar i = 0; i < NUM_FIFOS; i++) begin : g_fifo
         logic [4:0] nxt;
         logic       evt;

         always_comb begin
            nxt = count[i];
            evt = 1'b0;
            case ({push[i], pop[i]})
               2'b10: begin
                  if (count[i] == DEPTH) evt = 1'b1;          // overflow, saturate
                  else                   nxt = count[i] + 5'd1;
               end
               2'b01: begin
                  if (count[i] == 5'd0)  evt = 1'b1;          // underflow, stay 0
                  else                   nxt = count[i] - 5'd1;
               end
               2'b11: begin
                  // Simultaneous push/pop only matters when empty: the pop
                  // underflows and the push still lands.
                  if (count[i] == 5'd0) begin
                     nxt = 5'd1;
                     evt = 1'b1;
                  end
               end
               default: ;
            endcase
         end

         assign count_next[i]   = nxt;
         assign err_event[i]    = evt;

         assign empties[i]      = (count[i] == 5'd0);
         assign fulls[i]        = (count[i] == DEPTH);
         assign almost_empty[i] = (count[i] <= low_th[i]);
         assign almost_full[i]  = (count[i] >= high_th[i]);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_FIFOS; i++) count[i] <= 5'd0;
         errors    <= 5'd0;
         err_pulse <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_FIFOS; i++) count[i] <= count_next[i];
         errors    <= errors | err_event;
         // Pulse only for bits not already set, so repeat errors stay silent
         // and several bits setting together give a single pulse.
         err_pulse <= |(err_event & ~errors);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fifo_status_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_fifo_status_monitor                                     |
// | Description : Self-checking bench for fifo_status_monitor. A behavioural |
// |               occupancy model (integer counts, clamped) predicts every   |
// |               output; directed scenarios pin literal expectations and a  |
// |               randomized phase exercises the rest.                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_fifo_status_monitor;

   localparam int D = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] push, pop;
   logic [4:0] th_lo [5];
   logic [4:0] th_hi [5];
   logic [4:0] empties, fulls, almost_empty, almost_full, errors;
   logic       err_pulse;

   fifo_status_monitor #(.FIFO_DEPTH(D)) dut (
      .clk            (clk),
      .reset          (reset),
      .push           (push),
      .pop            (pop),
      .main_fifo_low  (th_lo[0]),
      .main_fifo_high (th_hi[0]),
      .Vco_low        (th_lo[1]),
      .Vco_high       (th_hi[1]),
      .Vc1_low        (th_lo[2]),
      .Vc1_high       (th_hi[2]),
      .Do_low         (th_lo[3]),
      .Do_high        (th_hi[3]),
      .D1_low         (th_lo[4]),
      .D1_high        (th_hi[4]),
      .empties        (empties),
      .fulls          (fulls),
      .almost_empty   (almost_empty),
      .almost_full    (almost_full),
      .errors         (errors),
      .err_pulse      (err_pulse)
   );

   always #5 clk = ~clk;

   // Behavioural model state
   int         mcnt [5];
   logic [4:0] merr;
   logic       mpulse;
   bit         model_ok = 1'b0;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Occupancy as a clamped integer: pop first (below zero is underflow),
   // then push (above depth is overflow).
   task automatic model_step();
      logic [4:0] newerr;
      if (reset) begin
         for (int i = 0; i < 5; i++) mcnt[i] = 0;
         merr   = 5'd0;
         mpulse = 1'b0;
      end else begin
         newerr = merr;
         for (int i = 0; i < 5; i++) begin
            int c;
            c = mcnt[i];
            if (pop[i]) begin
               c = c - 1;
               if (c < 0) begin c = 0; newerr[i] = 1'b1; end
            end
            if (push[i]) begin
               c = c + 1;
               if (c > D) begin c = D; newerr[i] = 1'b1; end
            end
            mcnt[i] = c;
         end
         mpulse = ((newerr & ~merr) != 5'd0);
         merr   = newerr;
      end
   endtask

   task automatic cycle(input logic [4:0] p, input logic [4:0] q, input logic r);
      push  = p;
      pop   = q;
      reset = r;
      @(posedge clk);
      model_step();
      #1;
      push  = 5'd0;
      pop   = 5'd0;
      reset = 1'b0;
   endtask

   // Single compare process: every output against the model, each cycle.
   always @(negedge clk) begin
      if (model_ok) begin
         logic [4:0] e_emp, e_full, e_ae, e_af;
         for (int i = 0; i < 5; i++) begin
            e_emp[i]  = (mcnt[i] == 0);
            e_full[i] = (mcnt[i] == D);
            e_ae[i]   = (mcnt[i] <= int'(th_lo[i]));
            e_af[i]   = (mcnt[i] >= int'(th_hi[i]));
         end
         chk("model.empties",      empties,      e_emp);
         chk("model.fulls",        fulls,        e_full);
         chk("model.almost_empty", almost_empty, e_ae);
         chk("model.almost_full",  almost_full,  e_af);
         chk("model.errors",       errors,       merr);
         chk("model.err_pulse",    err_pulse,    mpulse);
      end
   end

   initial begin
      push  = 5'd0;
      pop   = 5'd0;
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         th_lo[i] = 5'd2;
         th_hi[i] = 5'd14;
         mcnt[i]  = 0;
      end
      merr   = 5'd0;
      mpulse = 1'b0;

      cycle(5'd0, 5'd0, 1'b1);
      cycle(5'd0, 5'd0, 1'b1);
      model_ok = 1'b1;

      // Reset state, with main high threshold of zero
      th_hi[0] = 5'd0;
      #1;
      chk("rst.empties",      empties,      5'h1F);
      chk("rst.fulls",        fulls,        5'h00);
      chk("rst.almost_empty", almost_empty, 5'h1F);
      chk("rst.almost_full",  almost_full,  5'b00001);
      chk("rst.errors",       errors,       5'h00);
      chk("rst.err_pulse",    err_pulse,    1'b0);

      // Main FIFO threshold walk: low=3, high=6
      th_lo[0] = 5'd3;
      th_hi[0] = 5'd6;
      for (int k = 1; k <= 6; k++) begin
         cycle(5'b00001, 5'd0, 1'b0);
         if (k == 1) chk("main.empty_drop", empties[0], 1'b0);
         if (k == 3) chk("main.ae_at3",     almost_empty[0], 1'b1);
         if (k == 4) chk("main.ae_drop",    almost_empty[0], 1'b0);
         if (k == 5) chk("main.af_at5",     almost_full[0], 1'b0);
         if (k == 6) chk("main.af_rise",    almost_full[0], 1'b1);
      end

      // VC1 fill to 16 then overflow
      for (int k = 1; k <= 16; k++) cycle(5'b00100, 5'd0, 1'b0);
      chk("vc1.full16",     fulls[2],  1'b1);
      chk("vc1.noerr16",    errors[2], 1'b0);
      cycle(5'b00100, 5'd0, 1'b0);
      chk("vc1.ovf_err",    errors,    5'b00100);
      chk("vc1.ovf_pulse",  err_pulse, 1'b1);
      cycle(5'd0, 5'd0, 1'b0);
      chk("vc1.pulse_once", err_pulse, 1'b0);
      chk("vc1.still_full", fulls[2],  1'b1);
      cycle(5'd0, 5'b00100, 1'b0);
      chk("vc1.pop_15",     fulls[2],  1'b0);

      // D0 underflow from empty
      cycle(5'd0, 5'd0, 1'b1);
      cycle(5'd0, 5'b01000, 1'b0);
      chk("d0.unf_err",     errors,     5'b01000);
      chk("d0.unf_pulse",   err_pulse,  1'b1);
      chk("d0.still_empty", empties[3], 1'b1);
      cycle(5'd0, 5'b01000, 1'b0);
      chk("d0.no_2nd_pulse", err_pulse, 1'b0);

      // D1 push+pop at zero, then at five
      cycle(5'd0, 5'd0, 1'b1);
      th_lo[4] = 5'd0;
      th_hi[4] = 5'd2;
      cycle(5'b10000, 5'b10000, 1'b0);
      chk("d1.pp0_err",   errors,          5'b10000);
      chk("d1.pp0_pulse", err_pulse,       1'b1);
      chk("d1.pp0_ae",    almost_empty[4], 1'b0);
      chk("d1.pp0_af",    almost_full[4],  1'b0);
      cycle(5'd0, 5'd0, 1'b1);
      for (int k = 0; k < 5; k++) cycle(5'b10000, 5'd0, 1'b0);
      th_lo[4] = 5'd5;
      th_hi[4] = 5'd5;
      cycle(5'b10000, 5'b10000, 1'b0);
      chk("d1.pp5_err",   errors,          5'b00000);
      chk("d1.pp5_ae",    almost_empty[4], 1'b1);
      chk("d1.pp5_af",    almost_full[4],  1'b1);

      // All five pushed, then reset with pushes still asserted
      for (int k = 0; k < 3; k++) cycle(5'h1F, 5'd0, 1'b0);
      chk("all.burst_emp", empties, 5'h00);
      cycle(5'h1F, 5'h1F, 1'b1);
      chk("all.rst_emp",   empties, 5'h1F);
      chk("all.rst_err",   errors,  5'h00);

      // VC0 high threshold change acts without a strobe
      th_hi[1] = 5'd10;
      for (int k = 0; k < 4; k++) cycle(5'b00010, 5'd0, 1'b0);
      chk("vc0.af_before", almost_full[1], 1'b0);
      th_hi[1] = 5'd4;
      #1;
      chk("vc0.af_after",  almost_full[1], 1'b1);

      // Randomized phase, alternating push-heavy and pop-heavy stretches
      for (int k = 0; k < 3000; k++) begin
         logic [4:0] p, q;
         logic       r;
         if (((k / 250) % 2) == 0) begin
            p = 5'($urandom | $urandom);
            q = 5'($urandom & $urandom);
         end else begin
            p = 5'($urandom & $urandom);
            q = 5'($urandom | $urandom);
         end
         r = ($urandom_range(0, 399) == 0);
         if ($urandom_range(0, 49) == 0) begin
            for (int i = 0; i < 5; i++) begin
               th_lo[i] = 5'($urandom_range(0, 31));
               th_hi[i] = 5'($urandom_range(0, 31));
            end
         end
         cycle(p, q, r);
      end

      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
